// File: rtl/bp_perf_pkg.sv
// Shared types and defaults for the branch-predictor performance monitor.
package bp_perf_pkg;

  localparam int unsigned CNT_W_DEFAULT     = 32;
  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_006F;

  typedef enum logic [1:0] {PM_IDLE, PM_RUN, PM_DONE} pm_state_e;

  // Snapshot payload at the default counter width
  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] branches;
    logic [CNT_W_DEFAULT-1:0] misses;
    logic [CNT_W_DEFAULT-1:0] cycles;
    logic [CNT_W_DEFAULT-1:0] orphan;
  } snapshot_t;

endpackage

// File: rtl/bp_perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes the post-update value
// so a snapshot can include this cycle's increment.
module bp_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_c,
  output logic             sat_c
);

  localparam logic [CNT_W-1:0] MAX     = '1;
  localparam logic [CNT_W-1:0] SAT_PRE = MAX - CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  // sat_c flags the increment that lands on all-ones
  always_comb begin
    value_c = count_q;
    sat_c   = 1'b0;
    if (clr_i) begin
      value_c = '0;
    end else if (inc_i && (count_q != MAX)) begin
      value_c = count_q + CNT_W'(1);
      sat_c   = (count_q == SAT_PRE);
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= value_c;
  end

endmodule

// File: rtl/bp_perf_monitor.sv
// Branch/mispredict/cycle counters with halt detection and a valid/ready
// snapshot port. Define BP_PERF_STREAK_EN to add the max miss-streak field.
module bp_perf_monitor
  import bp_perf_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter logic [31:0] HALT_INSN = HALT_INSN_DEFAULT,
  parameter int unsigned HALT_CNT  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             br_instr_i,
  input  logic             br_miss_i,
  input  logic [31:0]      instr_i,
  input  logic             snap_req_i,
  output logic             snap_valid_o,
  input  logic             snap_ready_i,
  output logic [CNT_W-1:0] snap_branches_o,
  output logic [CNT_W-1:0] snap_misses_o,
  output logic [CNT_W-1:0] snap_cycles_o,
  output logic [CNT_W-1:0] snap_orphan_o,
`ifdef BP_PERF_STREAK_EN
  output logic [CNT_W-1:0] snap_max_streak_o,
`endif
  output logic             done_o,
  output logic             overflow_o
);

  localparam int unsigned     HALT_W   = $clog2(HALT_CNT + 1);
  localparam logic [HALT_W-1:0] HALT_MAX = HALT_W'(HALT_CNT);

  typedef struct packed {
    logic [CNT_W-1:0] branches;
    logic [CNT_W-1:0] misses;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] orphan;
  } snap_w_t;

  pm_state_e         state_q, state_d;
  logic [HALT_W-1:0] halt_run_q, halt_run_d;
  logic              run_c, to_done_c, accept_c;
  logic              inc_cyc_c, inc_br_c, inc_miss_c, inc_orph_c;
  logic              sat_cyc_c, sat_br_c, sat_miss_c, sat_orph_c, sat_any_c;
  logic [CNT_W-1:0]  cyc_c, br_c, miss_c, orph_c;
  logic              snap_valid_q, final_pend_q, done_q, overflow_q;
  snap_w_t           snap_q, snap_d;

  // Next state, halt-run tracking and capture arbitration
  always_comb begin
    state_d    = state_q;
    run_c      = 1'b0;
    to_done_c  = 1'b0;
    halt_run_d = '0;
    if (instr_i == HALT_INSN) begin
      halt_run_d = (halt_run_q == HALT_MAX) ? halt_run_q : halt_run_q + HALT_W'(1);
    end
    case (state_q)
      PM_IDLE: begin
        if (instr_i != '0) begin
          state_d = PM_RUN;
          run_c   = 1'b1;
        end
      end
      PM_RUN: begin
        run_c = 1'b1;
        if (halt_run_d == HALT_MAX) begin
          state_d   = PM_DONE;
          to_done_c = 1'b1;
        end
      end
      PM_DONE: begin
      end
      default: state_d = PM_IDLE;
    endcase
    accept_c = (state_q != PM_IDLE) && (snap_req_i || to_done_c || final_pend_q) &&
               (!snap_valid_q || snap_ready_i);
  end

  assign inc_cyc_c  = run_c;
  assign inc_br_c   = run_c & br_instr_i;
  assign inc_miss_c = run_c & br_instr_i & br_miss_i;
  assign inc_orph_c = run_c & br_miss_i & ~br_instr_i;

  bp_sat_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk_i(clk_i), .clr_i(rst_i), .inc_i(inc_cyc_c), .value_c(cyc_c), .sat_c(sat_cyc_c)
  );
  bp_sat_counter #(.CNT_W(CNT_W)) u_branches (
    .clk_i(clk_i), .clr_i(rst_i), .inc_i(inc_br_c), .value_c(br_c), .sat_c(sat_br_c)
  );
  bp_sat_counter #(.CNT_W(CNT_W)) u_misses (
    .clk_i(clk_i), .clr_i(rst_i), .inc_i(inc_miss_c), .value_c(miss_c), .sat_c(sat_miss_c)
  );
  bp_sat_counter #(.CNT_W(CNT_W)) u_orphan (
    .clk_i(clk_i), .clr_i(rst_i), .inc_i(inc_orph_c), .value_c(orph_c), .sat_c(sat_orph_c)
  );

  always_comb begin
    snap_d          = '0;
    snap_d.branches = br_c;
    snap_d.misses   = miss_c;
    snap_d.cycles   = cyc_c;
    snap_d.orphan   = orph_c;
  end

`ifdef BP_PERF_STREAK_EN
  logic             streak_sat_c;
  logic [CNT_W-1:0] streak_c, max_q, max_d, max_snap_q;

  // A correctly predicted branch ends the current miss streak
  bp_sat_counter #(.CNT_W(CNT_W)) u_streak (
    .clk_i(clk_i), .clr_i(rst_i | (run_c & br_instr_i & ~br_miss_i)),
    .inc_i(inc_miss_c), .value_c(streak_c), .sat_c(streak_sat_c)
  );

  always_comb begin
    max_d = max_q;
    if (run_c && (streak_c > max_q)) max_d = streak_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_q      <= '0;
      max_snap_q <= '0;
    end else begin
      max_q <= max_d;
      if (accept_c) max_snap_q <= max_d;
    end
  end

  assign snap_max_streak_o = max_snap_q;
  assign sat_any_c = sat_cyc_c | sat_br_c | sat_miss_c | sat_orph_c | streak_sat_c;
`else
  assign sat_any_c = sat_cyc_c | sat_br_c | sat_miss_c | sat_orph_c;
`endif

  // A blocked end-of-run capture stays pending until the handshake allows it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= PM_IDLE;
      halt_run_q   <= '0;
      snap_valid_q <= 1'b0;
      final_pend_q <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      halt_run_q   <= halt_run_d;
      final_pend_q <= (to_done_c || final_pend_q) && !accept_c;
      done_q       <= (state_d == PM_DONE);
      overflow_q   <= overflow_q | sat_any_c;
      if (accept_c) begin
        snap_valid_q <= 1'b1;
        snap_q       <= snap_d;
      end else if (snap_ready_i) begin
        snap_valid_q <= 1'b0;
      end
    end
  end

  assign snap_valid_o    = snap_valid_q;
  assign snap_branches_o = snap_q.branches;
  assign snap_misses_o   = snap_q.misses;
  assign snap_cycles_o   = snap_q.cycles;
  assign snap_orphan_o   = snap_q.orphan;
  assign done_o          = done_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Directed + random bench for bp_perf_monitor against a cycle-level count model.
module tb_bp_perf_monitor;
  import bp_perf_pkg::*;

  localparam logic [31:0] HALT  = HALT_INSN_DEFAULT;
  localparam int          HCNT  = 8;
  localparam longint      MAX32 = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, br, miss, req, ready, valid, done, ovf;
  logic [31:0] instr, s_br, s_miss, s_cyc, s_orph;
  logic        rst4, br4, miss4, req4, ready4, valid4, done4, ovf4;
  logic [31:0] instr4;
  logic [3:0]  s4_br, s4_miss, s4_cyc, s4_orph;
`ifdef BP_PERF_STREAK_EN
  logic [31:0] s_max;
  logic [3:0]  s4_max;
`endif

  bp_perf_monitor dut (
    .clk_i(clk), .rst_i(rst), .br_instr_i(br), .br_miss_i(miss), .instr_i(instr),
    .snap_req_i(req), .snap_valid_o(valid), .snap_ready_i(ready),
    .snap_branches_o(s_br), .snap_misses_o(s_miss), .snap_cycles_o(s_cyc),
    .snap_orphan_o(s_orph),
`ifdef BP_PERF_STREAK_EN
    .snap_max_streak_o(s_max),
`endif
    .done_o(done), .overflow_o(ovf)
  );

  bp_perf_monitor #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .br_instr_i(br4), .br_miss_i(miss4), .instr_i(instr4),
    .snap_req_i(req4), .snap_valid_o(valid4), .snap_ready_i(ready4),
    .snap_branches_o(s4_br), .snap_misses_o(s4_miss), .snap_cycles_o(s4_cyc),
    .snap_orphan_o(s4_orph),
`ifdef BP_PERF_STREAK_EN
    .snap_max_streak_o(s4_max),
`endif
    .done_o(done4), .overflow_o(ovf4)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 running, 2 finished
  int        m_state;
  longint    m_cyc, m_br, m_miss, m_orph;
  int        m_halt;
  bit        m_valid, m_pend;
  snapshot_t m_snap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sinc(input longint v);
    return (v == MAX32) ? v : v + 1;
  endfunction

  function automatic logic [31:0] rnd_insn();
    return $urandom & 32'hFFFF_FFFE;
  endfunction

  task automatic model_clear();
    m_state = 0; m_cyc = 0; m_br = 0; m_miss = 0; m_orph = 0;
    m_halt = 0; m_valid = 0; m_pend = 0; m_snap = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; br = 1'b0; miss = 1'b0; instr = '0; req = 1'b0; ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic tick(input logic b, input logic m, input logic [31:0] ins,
                      input logic rq, input logic rd);
    bit active, to_done, ok;
    br = b; miss = m; instr = ins; req = rq; ready = rd;
    @(posedge clk);
    active = (m_state == 1) || (m_state == 0 && ins != 0);
    if (active) begin
      m_cyc = sinc(m_cyc);
      if (b) m_br = sinc(m_br);
      if (b && m) m_miss = sinc(m_miss);
      if (m && !b) m_orph = sinc(m_orph);
    end
    m_halt  = (ins == HALT) ? m_halt + 1 : 0;
    to_done = (m_state == 1) && (m_halt >= HCNT);
    ok      = (m_state != 0) && (rq || to_done || m_pend) && (!m_valid || rd);
    m_pend  = (to_done || m_pend) && !ok;
    if (ok) begin
      m_valid         = 1'b1;
      m_snap.branches = 32'(m_br);
      m_snap.misses   = 32'(m_miss);
      m_snap.cycles   = 32'(m_cyc);
      m_snap.orphan   = 32'(m_orph);
    end else if (rd) begin
      m_valid = 1'b0;
    end
    if (m_state == 0 && ins != 0) m_state = 1;
    else if (to_done) m_state = 2;
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 64'(valid), 64'(m_valid));
    check({tag, ".done"}, 64'(done), 64'(m_state == 2));
    if (m_valid) begin
      check({tag, ".br"}, 64'(s_br), 64'(m_snap.branches));
      check({tag, ".miss"}, 64'(s_miss), 64'(m_snap.misses));
      check({tag, ".cyc"}, 64'(s_cyc), 64'(m_snap.cycles));
      check({tag, ".orph"}, 64'(s_orph), 64'(m_snap.orphan));
    end
  endtask

  task automatic tick4(input logic b, input logic m, input logic rq, input logic rd);
    br4 = b; miss4 = m; instr4 = 32'h13; req4 = rq; ready4 = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int ph, mph, k, exp_miss;
    logic [31:0] f_br, f_miss, f_cyc, f_orph;
    rst4 = 1'b1; br4 = 1'b0; miss4 = 1'b0; instr4 = '0; req4 = 1'b0; ready4 = 1'b0;
    rst = 1'b1; br = 1'b0; miss = 1'b0; instr = '0; req = 1'b0; ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst.valid", 64'(valid), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.ovf", 64'(ovf), 64'd0);
    check("rst.br", 64'(s_br), 64'd0);
    check("rst.cyc", 64'(s_cyc), 64'd0);
    check("rst.miss", 64'(s_miss), 64'd0);
    check("rst.orph", 64'(s_orph), 64'd0);

    // Idle: branch inputs and requests ignored
    for (int i = 0; i < 5; i++) begin
      tick(1'($urandom), 1'($urandom), 32'h0, 1'($urandom), 1'b1);
      check_model("idle");
    end
    check("idle.valid_low", 64'(valid), 64'd0);

    // Start on first nonzero fetch, snapshot three cycles later
    tick(1'b0, 1'b0, 32'h13, 1'b0, 1'b0);
    tick(1'b0, 1'b0, rnd_insn(), 1'b0, 1'b0);
    tick(1'b0, 1'b0, rnd_insn(), 1'b0, 1'b0);
    tick(1'b0, 1'b0, rnd_insn(), 1'b1, 1'b0);
    check_model("start");
    check("start.cyc4", 64'(s_cyc), 64'd4);
    check("start.br0", 64'(s_br), 64'd0);
    check("start.miss0", 64'(s_miss), 64'd0);

    // 100 cycles, branch every 4th cycle, miss on every 2nd branch
    ph = int'($urandom_range(0, 3));
    mph = int'($urandom_range(0, 1));
    k = 0;
    for (int i = 0; i < 100; i++) begin
      bit b, m;
      b = ((i + ph) % 4) == 0;
      m = 1'b0;
      if (b) begin
        m = ((k + mph) % 2) == 1;
        k++;
      end
      tick(b, m, rnd_insn(), i == 99, 1'b1);
    end
    exp_miss = (mph == 1) ? 13 : 12;
    check_model("pat");
    check("pat.br25", 64'(s_br), 64'd25);
    check("pat.miss", 64'(s_miss), 64'(exp_miss));
    check("pat.orph0", 64'(s_orph), 64'd0);

    // Orphan mispredicts
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, rnd_insn(), 1'b0, 1'b1);
    tick(1'b0, 1'b0, rnd_insn(), 1'b1, 1'b1);
    check_model("orph");
    check("orph.orph3", 64'(s_orph), 64'd3);
    check("orph.miss", 64'(s_miss), 64'(exp_miss));

    // Random traffic including dropped and coincident requests
    for (int i = 0; i < 60; i++) begin
      tick(1'($urandom), 1'($urandom), rnd_insn(), ($urandom % 4) == 0, ($urandom % 3) != 0);
      check_model("rnd");
    end

    // Halt detection: 7 matches, break, then 8 matches
    tick(1'b0, 1'b0, rnd_insn(), 1'b0, 1'b1);
    check("halt.drained", 64'(valid), 64'd0);
    for (int i = 0; i < 7; i++) tick(1'($urandom), 1'($urandom), HALT, 1'b0, 1'b0);
    tick(1'($urandom), 1'($urandom), 32'h13, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'($urandom), 1'($urandom), HALT, 1'b0, 1'b0);
      if (i == 6) check("halt.done7", 64'(done), 64'd0);
    end
    check("halt.done8", 64'(done), 64'd1);
    check_model("halt");
    f_br = m_snap.branches; f_miss = m_snap.misses; f_cyc = m_snap.cycles; f_orph = m_snap.orphan;
    for (int i = 0; i < 10; i++) begin
      tick(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'b0);
      check("hold.valid", 64'(valid), 64'd1);
      check("hold.br", 64'(s_br), 64'(f_br));
      check("hold.cyc", 64'(s_cyc), 64'(f_cyc));
    end
    tick(1'b1, 1'b1, rnd_insn(), 1'b1, 1'b1);
    check_model("frozen");
    check("frozen.cyc", 64'(s_cyc), 64'(f_cyc));
    check("frozen.miss", 64'(s_miss), 64'(f_miss));
    check("frozen.orph", 64'(s_orph), 64'(f_orph));
    check("frozen.ovf", 64'(ovf), 64'd0);

    // Final capture blocked by an unconsumed snapshot, then retried
    do_reset();
    check("rst2.valid", 64'(valid), 64'd0);
    tick(1'b0, 1'b0, 32'h13, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'($urandom), 1'($urandom), rnd_insn(), 1'b0, 1'b0);
    tick(1'b1, 1'b0, rnd_insn(), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'($urandom), 1'($urandom), HALT, 1'($urandom), 1'b0);
      check_model("blk");
    end
    check("blk.done", 64'(done), 64'd1);
    tick(1'b0, 1'b0, HALT, 1'b0, 1'b1);
    check_model("retry");
    check("retry.valid", 64'(valid), 64'd1);
    tick(1'b0, 1'b0, HALT, 1'b0, 1'b1);
    check_model("retry.consumed");

`ifdef BP_PERF_STREAK_EN
    do_reset();
    tick(1'b0, 1'b0, 32'h13, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, rnd_insn(), 1'b0, 1'b1);
    tick(1'b1, 1'b0, rnd_insn(), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, rnd_insn(), 1'b0, 1'b1);
    tick(1'b0, 1'b0, rnd_insn(), 1'b1, 1'b1);
    check_model("streak");
    check("streak.max", 64'(s_max), 64'd3);
`endif

    // Narrow-counter instance: saturation, dropped request, mid-run reset
    rst4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick4(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 13) check("sat.ovf_pre", 64'(ovf4), 64'd0);
    end
    check("sat.ovf", 64'(ovf4), 64'd1);
    tick4(1'b0, 1'b0, 1'b1, 1'b0);
    check("sat.valid", 64'(valid4), 64'd1);
    check("sat.br15", 64'(s4_br), 64'd15);
    check("sat.cyc15", 64'(s4_cyc), 64'd15);
    check("sat.orph0", 64'(s4_orph), 64'd0);
    tick4(1'b0, 1'b1, 1'b1, 1'b0);
    check("drop.valid", 64'(valid4), 64'd1);
    check("drop.orph", 64'(s4_orph), 64'd0);
    tick4(1'b0, 1'b1, 1'b1, 1'b1);
    check("upd.valid", 64'(valid4), 64'd1);
    check("upd.orph2", 64'(s4_orph), 64'd2);
    tick4(1'b0, 1'b0, 1'b0, 1'b0);
    check("sat.ovf_sticky", 64'(ovf4), 64'd1);
    rst4 = 1'b1;
    tick4(1'b1, 1'b1, 1'b1, 1'b0);
    rst4 = 1'b0;
    check("rst4.valid", 64'(valid4), 64'd0);
    check("rst4.br", 64'(s4_br), 64'd0);
    check("rst4.cyc", 64'(s4_cyc), 64'd0);
    check("rst4.ovf", 64'(ovf4), 64'd0);
    check("rst4.done", 64'(done4), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
